// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Single-beat request port -> APB master for two slaves (GPIO, UART).
//   Each request is decoded by address region and carried out as an APB
//   SETUP/ACCESS transfer. The selected slave's PREADY is waited on for at
//   most TIMEOUT_CYCLES ACCESS cycles. The result is returned on a
//   one-cycle rsp_valid strobe.
//
// Ports
//   PCLK, PRESETn        clock; async reset, active HIGH despite the name
//   req_valid/ready      request handshake (accept on valid && ready)
//   req_write/addr/wdata request direction, address, write data
//   rsp_valid/rdata/err  response strobe, read data, error flag
//   PSEL[1:0]            one-hot select: [0] GPIO, [1] UART
//   PENABLE, PWRITE      APB access phase, direction
//   PADDR, PWDATA        APB address, write data
//   PRDATA1/2, PREADY1/2 slave read data and ready (1 = GPIO, 2 = UART)
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for a request; req_ready = 1
//   ST_SETUP  | APB setup phase: PSEL asserted, PENABLE = 0
//   ST_ACCESS | APB access phase: PENABLE = 1, waiting on PREADY or timeout
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [1:0] PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Counter holds the number of ACCESS cycles already spent without PREADY,
  // so it never exceeds TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [7:0]    paddr_q, paddr_d;
  logic [7:0]    pwdata_q, pwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          sel_ready;
  logic [7:0]    sel_rdata;

  // Only the selected slave is observed; the other one's ready is ignored.
  assign sel_ready = (psel_q[0] & PREADY1) | (psel_q[1] & PREADY2);
  assign sel_rdata = psel_q[1] ? PRDATA2 : PRDATA1;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_addr[7:5] != 3'd0) begin
            // Region outside GPIO/UART: answer immediately, no bus cycle.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 8'h00;
          end else begin
            state_d  = ST_SETUP;
            psel_d   = req_addr[4] ? 2'b10 : 2'b01;
            pwrite_d = req_write;
            paddr_d  = {4'b0000, req_addr[3:0]};
            pwdata_d = req_wdata;
            cnt_d    = '0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          state_d     = ST_IDLE;
          psel_d      = 2'b00;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? 8'h00 : sel_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          psel_d      = 2'b00;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 2'b00;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 2'b00;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Directed scenarios with literal expectations, then randomized traffic
//   against a transaction-level model (phase = cycles since accept).
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic [7:0] PRDATA1 = 8'h00;
  logic [7:0] PRDATA2 = 8'h00;
  logic       PREADY1 = 1'b0;
  logic       PREADY2 = 1'b0;
  logic       req_ready, rsp_valid, rsp_err, PENABLE, PWRITE;
  logic [7:0] rsp_rdata, PADDR, PWDATA;
  logic [1:0] PSEL;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 PCLK = ~PCLK;

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = setup, k>=2 = (k-1)-th access cycle.
  int         m_phase = 0;
  logic       m_sel = 1'b0;
  logic       m_write = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  logic       m_rsp_valid = 1'b0;
  logic [7:0] m_rsp_rdata = 8'h00;
  logic       m_rsp_err = 1'b0;

  always @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      m_phase     <= 0;
      m_rsp_valid <= 1'b0;
      m_rsp_rdata <= 8'h00;
      m_rsp_err   <= 1'b0;
    end else begin
      m_rsp_valid <= 1'b0;
      if (m_phase == 0) begin
        if (req_valid) begin
          if (int'(req_addr[7:4]) > 1) begin
            m_rsp_valid <= 1'b1;
            m_rsp_err   <= 1'b1;
            m_rsp_rdata <= 8'h00;
          end else begin
            m_phase <= 1;
            m_sel   <= req_addr[4];
            m_write <= req_write;
            m_addr  <= req_addr;
            m_wdata <= req_wdata;
          end
        end
      end else if (m_phase == 1) begin
        m_phase <= 2;
      end else if ((m_sel ? PREADY2 : PREADY1) == 1'b1) begin
        m_phase     <= 0;
        m_rsp_valid <= 1'b1;
        m_rsp_err   <= 1'b0;
        m_rsp_rdata <= m_write ? 8'h00 : (m_sel ? PRDATA2 : PRDATA1);
      end else if (m_phase - 1 == TO) begin
        m_phase     <= 0;
        m_rsp_valid <= 1'b1;
        m_rsp_err   <= 1'b1;
        m_rsp_rdata <= 8'h00;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      chk("m_req_ready", req_ready, m_phase == 0);
      chk("m_psel", PSEL, (m_phase == 0) ? 0 : (m_sel ? 2 : 1));
      chk("m_penable", PENABLE, m_phase >= 2);
      chk("m_rsp_valid", rsp_valid, m_rsp_valid);
      chk("m_rsp_rdata", rsp_rdata, m_rsp_rdata);
      chk("m_rsp_err", rsp_err, m_rsp_err);
      if (m_phase != 0) begin
        chk("m_pwrite", PWRITE, m_write);
        chk("m_paddr", PADDR, {4'h0, m_addr[3:0]});
        chk("m_pwdata", PWDATA, m_wdata);
      end
    end
  end

  bit rnd_slave = 1'b0;
  always @(posedge PCLK) begin
    if (rnd_slave) begin
      #1;
      PREADY1 = ($urandom_range(0, 2) == 0);
      PREADY2 = ($urandom_range(0, 2) == 0);
      PRDATA1 = 8'($urandom);
      PRDATA2 = 8'($urandom);
    end
  end

  // Returns just after the accepting edge (edge N + 1ns).
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    int k = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge PCLK);
    while (!req_ready && k < 100) begin
      k++;
      @(negedge PCLK);
    end
    if (k >= 100) begin
      n_total++;
      n_bad++;
      $display("FAIL send_wait: got no req_ready expected req_ready within 100 cycles");
    end
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"}, PSEL, 0);
    chk({tag, "_penable"}, PENABLE, 0);
    chk({tag, "_pwrite"}, PWRITE, 0);
    chk({tag, "_paddr"}, PADDR, 0);
    chk({tag, "_pwdata"}, PWDATA, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    int k;
    int pen;
    bit done;
    logic [7:0] a;

    repeat (3) @(posedge PCLK);
    #1;
    chk_all_zero("rst");
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel", PSEL, 0);

    // GPIO write, zero-wait slave
    PREADY1 = 1'b1;
    send(1'b1, 8'h01, 8'hFF);
    @(negedge PCLK);
    chk("gw_setup_psel", PSEL, 2'b01);
    chk("gw_setup_pen", PENABLE, 0);
    chk("gw_setup_paddr", PADDR, 8'h01);
    chk("gw_setup_pwrite", PWRITE, 1);
    chk("gw_setup_pwdata", PWDATA, 8'hFF);
    @(negedge PCLK);
    chk("gw_access_pen", PENABLE, 1);
    chk("gw_access_psel", PSEL, 2'b01);
    @(negedge PCLK);
    chk("gw_rsp_valid", rsp_valid, 1);
    chk("gw_rsp_err", rsp_err, 0);
    chk("gw_rsp_rdata", rsp_rdata, 8'h00);
    chk("gw_rsp_psel", PSEL, 0);
    @(negedge PCLK);
    chk("gw_rsp_one_cycle", rsp_valid, 0);
    @(posedge PCLK);
    #1;

    // UART read, three wait states
    PREADY1 = 1'b1;
    PREADY2 = 1'b0;
    PRDATA2 = 8'h3C;
    send(1'b0, 8'h13, 8'h00);
    @(negedge PCLK);
    chk("ur_setup_psel", PSEL, 2'b10);
    chk("ur_setup_paddr", PADDR, 8'h03);
    chk("ur_setup_pen", PENABLE, 0);
    @(posedge PCLK);
    #1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        PREADY2 = 1'b1;
        PRDATA2 = 8'hA5;
      end
      @(negedge PCLK);
      chk("ur_access_pen", PENABLE, 1);
      chk("ur_access_psel", PSEL, 2'b10);
      chk("ur_access_rsp", rsp_valid, 0);
      @(posedge PCLK);
      #1;
    end
    PREADY2 = 1'b0;
    @(negedge PCLK);
    chk("ur_rsp_valid", rsp_valid, 1);
    chk("ur_rsp_rdata", rsp_rdata, 8'hA5);
    chk("ur_rsp_err", rsp_err, 0);
    chk("ur_rsp_pen", PENABLE, 0);
    @(posedge PCLK);
    #1;

    // Decode error
    send(1'b0, 8'h20, 8'h00);
    @(negedge PCLK);
    chk("de_rsp_valid", rsp_valid, 1);
    chk("de_rsp_err", rsp_err, 1);
    chk("de_rsp_rdata", rsp_rdata, 0);
    chk("de_psel", PSEL, 0);
    chk("de_req_ready", req_ready, 1);
    @(posedge PCLK);
    #1;

    // Timeout on GPIO read
    PREADY1 = 1'b0;
    PREADY2 = 1'b1;
    send(1'b0, 8'h05, 8'h00);
    pen = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (PENABLE) pen++;
      if (rsp_valid) done = 1'b1;
    end
    chk("to_seen_rsp", done, 1);
    chk("to_penable_cycles", pen, TO);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", PSEL, 0);
    PREADY2 = 1'b0;
    @(posedge PCLK);
    #1;

    // Back-to-back: valid held, second accepted in first rsp_valid cycle
    PREADY1 = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h00;
    req_wdata = 8'h11;
    @(negedge PCLK);
    @(posedge PCLK);
    #1;
    req_addr  = 8'h01;
    req_wdata = 8'h22;
    k = 0;
    do begin
      @(negedge PCLK);
      k++;
    end while (!req_ready && k < 10);
    chk("b2b_wait_cycles", k, 3);
    chk("b2b_rsp_valid", rsp_valid, 1);
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("b2b_second_psel", PSEL, 2'b01);
    chk("b2b_second_paddr", PADDR, 8'h01);
    chk("b2b_second_pwdata", PWDATA, 8'h22);
    repeat (4) @(posedge PCLK);
    #1;

    // Reset during ACCESS
    PREADY1 = 1'b0;
    send(1'b0, 8'h02, 8'h00);
    @(negedge PCLK);
    @(posedge PCLK);
    #2;
    chk("ra_in_access", PENABLE, 1);
    PRESETn = 1'b1;
    #1;
    chk_all_zero("ra");
    @(posedge PCLK);
    #1;
    PREADY1 = 1'b1;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("ra_no_rsp", rsp_valid, 0);
      chk("ra_psel", PSEL, 0);
      chk("ra_req_ready", req_ready, 1);
    end
    @(posedge PCLK);
    #1;

    // Randomized traffic
    rnd_slave = 1'b1;
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge PCLK);
        #1;
      end
      k = $urandom_range(0, 9);
      a = 8'($urandom);
      if (k < 4) a[7:4] = 4'h0;
      else if (k < 8) a[7:4] = 4'h1;
      else a[7:4] = 4'($urandom_range(2, 15));
      send(1'($urandom), a, 8'($urandom));
    end
    rnd_slave = 1'b0;
    repeat (TO + 8) @(posedge PCLK);
    #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB master that sits directly upstream of the GPIO APB slave and the UART APB slave. Converts single-beat requests from a simple valid/ready request port into APB SETUP/ACCESS transfers. Decodes the address to one of two slave selects, waits for the selected slave's PREADY with a bounded timeout, and returns read data and an error flag on a one-cycle response strobe.

Parameters:
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before the transfer is aborted with error (must be >= 1)

Ports:
PCLK  in  1  system clock, all state on rising edge
PRESETn  in  1  asynchronous reset, active-high (asserted when 1, despite the name)
req_valid  in  1  request present
req_ready  out  1  bridge can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  8  [7:4] slave region, [3:0] register offset
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  8  read data (0 for writes and errors)
rsp_err  out  1  decode error or timeout; valid with rsp_valid
PSEL  out  2  one-hot slave select: [0] GPIO, [1] UART
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction
PADDR  out  8  APB address
PWDATA  out  8  APB write data
PRDATA1  in  8  read data from GPIO slave
PRDATA2  in  8  read data from UART slave
PREADY1  in  1  ready from GPIO slave
PREADY2  in  1  ready from UART slave

Behaviour:
- Reset (async, while PRESETn=1): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0. req_ready=1 once reset is released.
- req_ready = (state==IDLE), combinational from state only. A request is accepted on the rising edge where req_valid && req_ready.
- Decode: req_addr[7:4]==0 -> GPIO (PSEL=2'b01); ==1 -> UART (PSEL=2'b10); any other value -> decode error.
- PADDR = {4'b0, req_addr[3:0]}. PWRITE, PADDR and PWDATA are registered at accept and held stable through SETUP and ACCESS. They keep their last values in IDLE.
- FSM:
  - IDLE: on accept with a valid decode -> SETUP. On accept with a decode error -> stay IDLE and register rsp_valid=1, rsp_err=1, rsp_rdata=0 for one cycle; no APB activity.
  - SETUP (1 cycle): PSEL one-hot, PENABLE=0 -> ACCESS unconditionally.
  - ACCESS: PSEL held, PENABLE=1. Only the selected slave's PREADY/PRDATA are observed.
    - If PREADY is sampled high: next cycle PSEL=0, PENABLE=0, state IDLE, rsp_valid=1, rsp_err=0, rsp_rdata = selected PRDATA for reads (0 for writes).
    - If PREADY is low: counter increments. If PREADY is still low in the TIMEOUT_CYCLES-th ACCESS cycle, abort: next cycle PSEL=0, PENABLE=0, IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Counter clears on entry to SETUP.
- Latency: with zero-wait slave, accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; rsp_valid in cycle N+3. ACCESS lasts at most TIMEOUT_CYCLES cycles.
- rsp_valid is high for exactly one cycle per accepted request. rsp_rdata and rsp_err are held until the next response.
- Back-to-back: the bridge is in IDLE during the rsp_valid cycle, so a new request can be accepted there. Successive transfers therefore have no dead cycle beyond IDLE.
- Requests are never queued; req_valid while not ready is ignored (the requester holds it).
- PREADY of the non-selected slave, and any PREADY in IDLE or SETUP, is ignored.
- Reset mid-transfer: outputs go to reset values immediately. No rsp_valid is issued for the aborted transfer.

Test Plan:
- Reset: assert PRESETn=1 mid-simulation -> all outputs 0 asynchronously. After release, req_ready=1 and PSEL=00.
- GPIO write: addr 0x01, wdata 0xFF, PREADY1=1 -> SETUP cycle has PSEL=01, PENABLE=0, PADDR=0x01, PWRITE=1, PWDATA=0xFF. Next cycle PENABLE=1. rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0x00.
- UART read with wait states: addr 0x13, PREADY2 low for 3 ACCESS cycles then high with PRDATA2=0xA5 -> PSEL=10, PADDR=0x03, ACCESS lasts 4 cycles, rsp_rdata=0xA5, rsp_err=0.
- Decode error: addr 0x20 -> PSEL stays 00, rsp_valid=1 with rsp_err=1 in the cycle after accept, req_ready stays 1.
- Timeout: GPIO read with PREADY1 held 0 -> PENABLE high exactly 16 cycles, then PSEL=00, rsp_valid=1, rsp_err=1, rsp_rdata=0x00.
- Back-to-back and reset abort: req_valid held for writes 0x00 then 0x01 -> second accepted in first rsp_valid cycle. Reset asserted during an ACCESS -> PSEL/PENABLE drop the same cycle and no rsp_valid follows.
